// File: rtl/riscv_pkg.sv
// Shared decode types: immediate format encoding, control bundle layout and defaults.
package riscv_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_src_e;

  // Layout owned by the external control unit; decode treats it as opaque bits.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       mem_read;
    logic       jump;
    logic       branch;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    logic [4:0] alu_ctrl;
    logic [2:0] funct3;
    logic [2:0] imm_src;
    logic [2:0] rsvd;
  } ctrl_t;

  localparam int unsigned CTRL_W_DEF = $bits(ctrl_t);

endpackage

// File: rtl/decode_pipe_if.sv
// Fetch-side and execute-side handshake bundles of the decode stage.
// master = surrounding pipeline (fetch + execute), slave = decode_pipe.
interface decode_pipe_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned CTRL_W = 24
);
  logic              ValidF;
  logic              ReadyF;
  logic [31:0]       InstrF;
  logic [XLEN-1:0]   PCF;
  logic [XLEN-1:0]   PCPlus4F;

  logic              ValidE;
  logic              ReadyE;
  logic [XLEN-1:0]   PCE;
  logic [XLEN-1:0]   PCPlus4E;
  logic [XLEN-1:0]   RD1E;
  logic [XLEN-1:0]   RD2E;
  logic [XLEN-1:0]   ImmExtE;
  logic [AW-1:0]     Rs1E;
  logic [AW-1:0]     Rs2E;
  logic [AW-1:0]     RdE;
  logic [CTRL_W-1:0] CtrlE;

  modport master (
    output ValidF, InstrF, PCF, PCPlus4F, ReadyE,
    input  ReadyF, ValidE, PCE, PCPlus4E, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, CtrlE
  );

  modport slave (
    input  ValidF, InstrF, PCF, PCPlus4F, ReadyE,
    output ReadyF, ValidE, PCE, PCPlus4E, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, CtrlE
  );
endinterface

// File: rtl/decode_pipe_imm_gen.sv
// Immediate generator: sign-extends the I/S/B/U/J immediate of an instruction to XLEN.
// Only bits [31:7] carry immediate fields, so the opcode bits are not routed in.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [31:7]     InstrD,
  input  logic [2:0]      ImmSrcD,
  output logic [XLEN-1:0] ImmExt
);

  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_src_e'(ImmSrcD))
      IMM_I:   imm32 = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S:   imm32 = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   imm32 = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      IMM_U:   imm32 = {InstrD[31:12], 12'b0};
      IMM_J:   imm32 = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Signed source: the size cast sign-extends for XLEN = 64.
  assign ImmExt = XLEN'(imm32);

endmodule

// File: rtl/decode_pipe.sv
// Decode stage: IF/ID register, register file with writeback bypass, immediates, ID/EX register.
// Optional DECODE_PERF_EN adds saturating StallCnt / BubbleCnt outputs.
module decode_pipe
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREG   = 32,
  parameter int unsigned AW     = $clog2(NREG),
  parameter int unsigned CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  decode_pipe_if.slave      bus,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [2:0]        ImmSrcD,
  output logic [31:0]       InstrD,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  input  logic              RegWriteW,
  input  logic [AW-1:0]     RdW,
  input  logic [XLEN-1:0]   ResultW
`ifdef DECODE_PERF_EN
  ,
  output logic [31:0]       StallCnt,
  output logic [31:0]       BubbleCnt
`endif
);

  localparam int unsigned DEPTH = 1 << AW;

  logic            valid_d;
  logic [31:0]     instr_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc4_d;

  logic adv_d, load_e, ready_f, take_f, wr_hit;

  assign adv_d   = valid_d & ~StallD & (bus.ReadyE | ~bus.ValidE);
  assign load_e  = bus.ReadyE | ~bus.ValidE;
  assign ready_f = FlushD | ~valid_d | adv_d;
  assign take_f  = bus.ValidF & ready_f;

  assign bus.ReadyF = ready_f;
  assign InstrD     = instr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_d <= 1'b0;
      instr_d <= '0;
      pc_d    <= '0;
      pc4_d   <= '0;
    end else if (FlushD) begin
      valid_d <= 1'b0;
    end else if (take_f) begin
      valid_d <= 1'b1;
      instr_d <= bus.InstrF;
      pc_d    <= bus.PCF;
      pc4_d   <= bus.PCPlus4F;
    end else if (adv_d) begin
      valid_d <= 1'b0;
    end
  end

  // Storage kept as one flat vector so reset and write live in a single process.
  logic [DEPTH*XLEN-1:0] regs;
  logic [AW-1:0]         rs1, rs2, rd;
  logic [XLEN-1:0]       rd1, rd2;

  assign rs1    = instr_d[15 +: AW];
  assign rs2    = instr_d[20 +: AW];
  assign rd     = instr_d[7 +: AW];
  assign wr_hit = RegWriteW & (RdW != AW'(REG_ZERO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      regs <= '0;
    else if (wr_hit) regs[RdW*XLEN +: XLEN] <= ResultW;
  end

  always_comb begin
    rd1 = regs[rs1*XLEN +: XLEN];
    rd2 = regs[rs2*XLEN +: XLEN];
    if (wr_hit && RdW == rs1) rd1 = ResultW;
    if (wr_hit && RdW == rs2) rd2 = ResultW;
    if (rs1 == AW'(REG_ZERO)) rd1 = '0;
    if (rs2 == AW'(REG_ZERO)) rd2 = '0;
  end

  logic [XLEN-1:0] imm_ext;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .InstrD  (instr_d[31:7]),
    .ImmSrcD (ImmSrcD),
    .ImmExt  (imm_ext)
  );

  logic              valid_e;
  logic [XLEN-1:0]   pc_e, pc4_e, rd1_e, rd2_e, imm_e;
  logic [AW-1:0]     rs1_e, rs2_e, rd_e;
  logic [CTRL_W-1:0] ctrl_e;

  // A bubble clears only valid and control; operand data is left as it was.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_e <= 1'b0;
      pc_e    <= '0;
      pc4_e   <= '0;
      rd1_e   <= '0;
      rd2_e   <= '0;
      imm_e   <= '0;
      rs1_e   <= '0;
      rs2_e   <= '0;
      rd_e    <= '0;
      ctrl_e  <= '0;
    end else begin
      if (load_e) begin
        if (adv_d) begin
          valid_e <= 1'b1;
          pc_e    <= pc_d;
          pc4_e   <= pc4_d;
          rd1_e   <= rd1;
          rd2_e   <= rd2;
          imm_e   <= imm_ext;
          rs1_e   <= rs1;
          rs2_e   <= rs2;
          rd_e    <= rd;
          ctrl_e  <= CtrlD;
        end else begin
          valid_e <= 1'b0;
          ctrl_e  <= '0;
        end
      end
      if (FlushE) begin
        valid_e <= 1'b0;
        ctrl_e  <= '0;
      end
    end
  end

  assign bus.ValidE   = valid_e;
  assign bus.PCE      = pc_e;
  assign bus.PCPlus4E = pc4_e;
  assign bus.RD1E     = rd1_e;
  assign bus.RD2E     = rd2_e;
  assign bus.ImmExtE  = imm_e;
  assign bus.Rs1E     = rs1_e;
  assign bus.Rs2E     = rs2_e;
  assign bus.RdE      = rd_e;
  assign bus.CtrlE    = ctrl_e;

`ifdef DECODE_PERF_EN
  logic bubble;
  assign bubble = (load_e & ~adv_d) | FlushE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCnt  <= '0;
      BubbleCnt <= '0;
    end else begin
      if (valid_d && StallD && !(&StallCnt)) StallCnt  <= StallCnt + 32'd1;
      if (bubble && !(&BubbleCnt))          BubbleCnt <= BubbleCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe: vector table, directed pipeline sequences and random traffic
// against a transaction-level model of the two pipeline slots and the register file.
module tb_decode_pipe;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned CW   = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_pipe_if #(.XLEN(XLEN), .AW(AW), .CTRL_W(CW)) bus ();

  logic [CW-1:0]   CtrlD;
  logic [2:0]      ImmSrcD;
  logic [31:0]     InstrD;
  logic            StallD, FlushD, FlushE, RegWriteW;
  logic [AW-1:0]   RdW;
  logic [XLEN-1:0] ResultW;
`ifdef DECODE_PERF_EN
  logic [31:0]     StallCnt, BubbleCnt;
`endif

  decode_pipe #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .CTRL_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .CtrlD     (CtrlD),
    .ImmSrcD   (ImmSrcD),
    .InstrD    (InstrD),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .RegWriteW (RegWriteW),
    .RdW       (RdW),
    .ResultW   (ResultW)
`ifdef DECODE_PERF_EN
    ,
    .StallCnt  (StallCnt),
    .BubbleCnt (BubbleCnt)
`endif
  );

  // Stand-in control unit: immediate format from the opcode, a nonzero control word.
  function automatic logic [2:0] imm_src_of(input logic [31:0] i);
    case (i[6:0])
      7'h13, 7'h03, 7'h67: return 3'd0;
      7'h23:               return 3'd1;
      7'h63:               return 3'd2;
      7'h37, 7'h17:        return 3'd3;
      7'h6F:               return 3'd4;
      default:             return i[14:12];
    endcase
  endfunction

  function automatic logic [CW-1:0] ctrl_of(input logic [31:0] i);
    return {i[31:20], i[11:0]} | 24'h000001;
  endfunction

  always_comb begin
    ImmSrcD = imm_src_of(InstrD);
    CtrlD   = ctrl_of(InstrD);
  end

  // Immediate value by field weighting and two's-complement wrap.
  function automatic logic [31:0] model_imm(input logic [31:0] i, input logic [2:0] src);
    longint u, v;
    u = i;
    v = 0;
    case (src)
      3'd0: begin v = (u >> 20) & 4095; if (v >= 2048) v -= 4096; end
      3'd1: begin v = ((u >> 25) << 5) + ((u >> 7) & 31); if (v >= 2048) v -= 4096; end
      3'd2: begin
        v = (((u >> 8) & 15) << 1) + (((u >> 25) & 63) << 5) + (((u >> 7) & 1) << 11) + ((u >> 31) << 12);
        if (v >= 4096) v -= 8192;
      end
      3'd3: begin v = u & 64'hFFFF_F000; if (v >= (longint'(1) << 31)) v -= (longint'(1) << 32); end
      3'd4: begin
        v = (((u >> 21) & 1023) << 1) + (((u >> 20) & 1) << 11) + (((u >> 12) & 255) << 12) + ((u >> 31) << 20);
        if (v >= (longint'(1) << 20)) v -= (longint'(1) << 21);
      end
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model state: decode slot, execute slot, architectural registers, event counts.
  bit          md_v;
  logic [31:0] md_i, md_pc, md_pc4;
  bit          me_v;
  logic [31:0] me_pc, me_pc4, me_rd1, me_rd2, me_imm;
  logic [4:0]  me_rs1, me_rs2, me_rd;
  logic [CW-1:0] me_ctrl;
  logic [31:0] m_reg [NREG];
  int unsigned m_stall, m_bub;

  task automatic model_reset();
    md_v = 0; md_i = '0; md_pc = '0; md_pc4 = '0;
    me_v = 0; me_pc = '0; me_pc4 = '0; me_rd1 = '0; me_rd2 = '0; me_imm = '0;
    me_rs1 = '0; me_rs2 = '0; me_rd = '0; me_ctrl = '0;
    for (int i = 0; i < int'(NREG); i++) m_reg[i] = '0;
    m_stall = 0; m_bub = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 0) return '0;
    if (RegWriteW && RdW == idx) return ResultW;
    return m_reg[idx];
  endfunction

  task automatic idle_inputs();
    bus.ValidF = 0; bus.InstrF = '0; bus.PCF = '0; bus.PCPlus4F = '0; bus.ReadyE = 1;
    StallD = 0; FlushD = 0; FlushE = 0; RegWriteW = 0; RdW = '0; ResultW = '0;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    bus.ValidF = 1; bus.InstrF = instr; bus.PCF = pc; bus.PCPlus4F = pc + 32'd4;
  endtask

  // One clock: check the combinational view mid-cycle, advance the model, check registered outputs.
  task automatic cycle();
    bit adv, lde, rdy, take;
    logic [31:0] r1, r2;
    @(negedge clk);
    adv = md_v && !StallD && (bus.ReadyE || !me_v);
    lde = bus.ReadyE || !me_v;
    rdy = FlushD || !md_v || adv;
    chk("ReadyF", bus.ReadyF, rdy);
    if (md_v) chk("InstrD", InstrD, md_i);
    r1 = model_read(md_i[19:15]);
    r2 = model_read(md_i[24:20]);
    take = bus.ValidF && rdy;
    @(posedge clk);
    #1;
    if (lde) begin
      if (adv) begin
        me_v = 1; me_pc = md_pc; me_pc4 = md_pc4; me_rd1 = r1; me_rd2 = r2;
        me_imm = model_imm(md_i, imm_src_of(md_i));
        me_rs1 = md_i[19:15]; me_rs2 = md_i[24:20]; me_rd = md_i[11:7];
        me_ctrl = ctrl_of(md_i);
      end else begin
        me_v = 0; me_ctrl = '0;
      end
    end
    if (FlushE) begin me_v = 0; me_ctrl = '0; end
    if (md_v && StallD) m_stall++;
    if ((lde && !adv) || FlushE) m_bub++;
    if (FlushD) md_v = 0;
    else if (take) begin md_v = 1; md_i = bus.InstrF; md_pc = bus.PCF; md_pc4 = bus.PCPlus4F; end
    else if (adv) md_v = 0;
    if (RegWriteW && RdW != 0) m_reg[RdW] = ResultW;
    chk("ValidE", bus.ValidE, me_v);
    chk("CtrlE", bus.CtrlE, me_ctrl);
    if (me_v) begin
      chk("PCE", bus.PCE, me_pc);
      chk("PCPlus4E", bus.PCPlus4E, me_pc4);
      chk("RD1E", bus.RD1E, me_rd1);
      chk("RD2E", bus.RD2E, me_rd2);
      chk("ImmExtE", bus.ImmExtE, me_imm);
      chk("Rs1E", bus.Rs1E, me_rs1);
      chk("Rs2E", bus.Rs2E, me_rs2);
      chk("RdE", bus.RdE, me_rd);
    end
`ifdef DECODE_PERF_EN
    chk("StallCnt", StallCnt, m_stall);
    chk("BubbleCnt", BubbleCnt, m_bub);
`endif
  endtask

  task automatic chk_e_zero(input string tag);
    chk({tag, "_ValidE"}, bus.ValidE, 0);
    chk({tag, "_CtrlE"}, bus.CtrlE, 0);
    chk({tag, "_PCE"}, bus.PCE, 0);
    chk({tag, "_RD1E"}, bus.RD1E, 0);
    chk({tag, "_ImmExtE"}, bus.ImmExtE, 0);
    chk({tag, "_RdE"}, bus.RdE, 0);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs[7];

  initial begin
`ifdef DECODE_PERF_EN
    int unsigned s0, b0;
`endif
    vecs[0] = '{32'h0050_0093, 32'h0000_0000, 32'h0000_0005, 5'd1};
    vecs[1] = '{32'hFE00_0EE3, 32'h0000_0010, 32'hFFFF_FFFC, 5'd29};
    vecs[2] = '{32'h1234_5037, 32'h0000_0020, 32'h1234_5000, 5'd0};
    vecs[3] = '{32'hFFF0_0113, 32'h0000_0030, 32'hFFFF_FFFF, 5'd2};
    vecs[4] = '{32'hFE11_2E23, 32'h0000_0040, 32'hFFFF_FFFC, 5'd28};
    vecs[5] = '{32'hFF9F_F0EF, 32'h0000_0050, 32'hFFFF_FFF8, 5'd1};
    vecs[6] = '{32'h7FF0_5033, 32'h0000_0060, 32'h0000_0000, 5'd0};

    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_e_zero("reset");
    chk("reset_ReadyF", bus.ReadyF, 1);
    @(posedge clk);
    #1;
    rst_n = 1;

    // Table: each instruction reaches E exactly two edges after it is offered.
    for (int unsigned k = 0; k < 7; k++) begin
      offer(vecs[k].instr, vecs[k].pc);
      cycle();
      chk("tbl_latency_ValidE", bus.ValidE, 0);
      bus.ValidF = 0;
      cycle();
      chk("tbl_ValidE", bus.ValidE, 1);
      chk("tbl_PCE", bus.PCE, vecs[k].pc);
      chk("tbl_ImmExtE", bus.ImmExtE, vecs[k].imm);
      chk("tbl_RdE", bus.RdE, vecs[k].rd);
    end

    // Writeback bypass into a same-cycle read, then x0 ignoring writes, then a plain file read.
    offer(32'h0001_82B3, 32'h100);
    cycle();
    bus.ValidF = 0; RegWriteW = 1; RdW = 5'd3; ResultW = 32'hDEAD_BEEF;
    cycle();
    chk("bypass_RD1E", bus.RD1E, 32'hDEAD_BEEF);
    RegWriteW = 0;
    offer(32'h0000_0333, 32'h104);
    cycle();
    bus.ValidF = 0; RegWriteW = 1; RdW = 5'd0; ResultW = 32'h1234_5678;
    cycle();
    chk("x0_RD1E", bus.RD1E, 0);
    chk("x0_RD2E", bus.RD2E, 0);
    RegWriteW = 0;
    offer(32'h0001_8433, 32'h108);
    cycle();
    bus.ValidF = 0;
    cycle();
    chk("regfile_RD1E", bus.RD1E, 32'hDEAD_BEEF);

    // Load-use stall for two cycles.
    offer(32'h0050_0093, 32'h200);
    cycle();
`ifdef DECODE_PERF_EN
    s0 = m_stall; b0 = m_bub;
`endif
    offer(32'h0010_0113, 32'h204);
    StallD = 1;
    cycle();
    cycle();
    chk("stall_ValidE", bus.ValidE, 0);
    chk("stall_CtrlE", bus.CtrlE, 0);
    chk("stall_InstrD", InstrD, 32'h0050_0093);
    chk("stall_ReadyF", bus.ReadyF, 0);
`ifdef DECODE_PERF_EN
    chk("stall_StallCnt", StallCnt, s0 + 2);
    chk("stall_BubbleCnt", BubbleCnt, b0 + 2);
`endif
    StallD = 0;
    cycle();
    chk("stall_issue_ValidE", bus.ValidE, 1);
    chk("stall_issue_PCE", bus.PCE, 32'h200);
    bus.ValidF = 0;
    cycle();

    // Backpressure: execute refuses for three cycles with both slots full.
    offer(32'h0030_0193, 32'h400);
    cycle();
    offer(32'h0040_0213, 32'h404);
    cycle();
    offer(32'h0050_0293, 32'h408);
    bus.ReadyE = 0;
    repeat (3) cycle();
    chk("bp_hold_PCE", bus.PCE, 32'h400);
    chk("bp_ReadyF", bus.ReadyF, 0);
    bus.ReadyE = 1;
    cycle();
    chk("bp_rel1_PCE", bus.PCE, 32'h404);
    bus.ValidF = 0;
    cycle();
    chk("bp_rel2_PCE", bus.PCE, 32'h408);
    cycle();
    chk("bp_drain_ValidE", bus.ValidE, 0);

    // Flush of both stages while stalled and while fetch offers.
    offer(32'h0060_0313, 32'h300);
    cycle();
    offer(32'h0070_0393, 32'h304);
    cycle();
    offer(32'h0080_0413, 32'h308);
    StallD = 1; FlushD = 1; FlushE = 1;
    cycle();
    chk("flush_ValidE", bus.ValidE, 0);
    chk("flush_CtrlE", bus.CtrlE, 0);
    idle_inputs();
    cycle();
    chk("flush_discard_ValidE", bus.ValidE, 0);

    // Reset arriving mid-stall empties both stages and the register file.
    offer(32'h0090_0493, 32'h500);
    cycle();
    offer(32'h00A0_0513, 32'h504);
    cycle();
    StallD = 1;
    cycle();
    #2;
    rst_n = 0;
    #1;
    chk_e_zero("midrst");
    chk("midrst_ReadyF", bus.ReadyF, 1);
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    cycle();
    chk("midrst_after_ValidE", bus.ValidE, 0);
    offer(32'h0001_8433, 32'h600);
    cycle();
    bus.ValidF = 0;
    cycle();
    chk("midrst_regfile_RD1E", bus.RD1E, 0);

    // Random traffic against the model.
    for (int unsigned n = 0; n < 3000; n++) begin
      bus.ValidF   = ($urandom_range(0, 9) < 7);
      bus.InstrF   = $urandom;
      bus.PCF      = $urandom & 32'hFFFF_FFFC;
      bus.PCPlus4F = bus.PCF + 32'd4;
      bus.ReadyE   = ($urandom_range(0, 3) != 0);
      StallD       = ($urandom_range(0, 19) < 3);
      FlushD       = ($urandom_range(0, 19) == 0);
      FlushE       = ($urandom_range(0, 19) == 0);
      RegWriteW    = $urandom_range(0, 1);
      RdW          = ($urandom_range(0, 9) < 3) ? md_i[19:15] : AW'($urandom_range(0, 31));
      ResultW      = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
